// File: rtl/water_pkg.sv
// rtl/water_pkg.sv - shared constants, types and palette for the water sprite generator
package water_pkg;

    localparam int COORD_W    = 11;
    localparam int SPR_W_LOG2 = 4;
    localparam int SPR_H_LOG2 = 4;
    localparam int ANIM_LOG2  = 2;
    localparam int ADDR_WIDTH = SPR_W_LOG2 + SPR_H_LOG2 + ANIM_LOG2;
    localparam int ANIM_DIV   = 8;

    localparam logic [11:0] PAL_LIGHT = 12'h4AF;
    localparam logic [11:0] PAL_MID   = 12'h07F;
    localparam logic [11:0] PAL_FOAM  = 12'hFFF;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [11:0]        rgb_t;

    function automatic rgb_t palette(input logic [1:0] idx);
        rgb_t c;
        case (idx)
            2'b01:   c = PAL_LIGHT;
            2'b10:   c = PAL_MID;
            2'b11:   c = PAL_FOAM;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/water_sprite_gen_if.sv
// rtl/water_sprite_gen_if.sv - read port between the sprite generator and the 2-bit bitmap RAM
interface water_sprite_gen_if #(
    parameter int ADDR_WIDTH = 10
) ();
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [1:0]            ram_dout;

    modport master (output addr_r, input ram_dout);
    modport slave  (input addr_r, output ram_dout);
endinterface

// File: rtl/water_sprite_gen_anim_ctr.sv
// rtl/water_sprite_gen_anim_ctr.sv - frame divider and animation frame index
module water_anim_ctr #(
    parameter int ANIM_LOG2 = 2,
    parameter int ANIM_DIV  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    input  logic                 anim_en,
    output logic [ANIM_LOG2-1:0] anim_idx
);

    // Keep the divider at least one bit wide so ANIM_DIV=1 still elaborates.
    localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);

    logic [DIV_W-1:0]     r_div_cnt;
    logic [ANIM_LOG2-1:0] r_anim_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt  <= '0;
            r_anim_idx <= '0;
        end else if (frame_tick && anim_en) begin
            if (r_div_cnt == DIV_LAST) begin
                r_div_cnt  <= '0;
                r_anim_idx <= r_anim_idx + 1'b1;
            end else begin
                r_div_cnt  <= r_div_cnt + 1'b1;
            end
        end
    end

    assign anim_idx = r_anim_idx;

endmodule

// File: rtl/water_sprite_gen.sv
// rtl/water_sprite_gen.sv - pixel coordinate to bitmap address, bitmap index to RGB + enable
module water_sprite_gen
    import water_pkg::*;
#(
    parameter int COORD_W    = water_pkg::COORD_W,
    parameter int SPR_W_LOG2 = water_pkg::SPR_W_LOG2,
    parameter int SPR_H_LOG2 = water_pkg::SPR_H_LOG2,
    parameter int ANIM_LOG2  = water_pkg::ANIM_LOG2,
    parameter int ADDR_WIDTH = water_pkg::ADDR_WIDTH,
    parameter int ANIM_DIV   = water_pkg::ANIM_DIV
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               frame_tick,
    input  logic               anim_en,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    water_sprite_gen_if.master bmp,
    output rgb_t               rgb,
    output logic               en
);

    generate
        if (ADDR_WIDTH != SPR_W_LOG2 + SPR_H_LOG2 + ANIM_LOG2) begin : g_bad_addr_width
            $error("ADDR_WIDTH must equal SPR_W_LOG2+SPR_H_LOG2+ANIM_LOG2");
        end
    endgenerate

    localparam logic [COORD_W:0] SPR_W = (COORD_W+1)'(1 << SPR_W_LOG2);
    localparam logic [COORD_W:0] SPR_H = (COORD_W+1)'(1 << SPR_H_LOG2);

    logic [COORD_W-1:0]    r_px, r_py;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_hit_d1, r_hit_d2;
    rgb_t                  r_rgb;
    logic                  r_en;

    logic [ANIM_LOG2-1:0]  w_anim_idx;
    logic [COORD_W:0]      w_x_end, w_y_end;
    logic                  w_hit;
    logic [SPR_W_LOG2-1:0] w_dx;
    logic [SPR_H_LOG2-1:0] w_dy;
    logic                  w_en_next;

    water_anim_ctr #(
        .ANIM_LOG2 (ANIM_LOG2),
        .ANIM_DIV  (ANIM_DIV)
    ) u_anim_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .anim_en    (anim_en),
        .anim_idx   (w_anim_idx)
    );

    // Position is sampled once per frame so a mid-frame move cannot tear the sprite.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_px <= '0;
            r_py <= '0;
        end else if (frame_tick) begin
            r_px <= pos_x;
            r_py <= pos_y;
        end
    end

    // One extra bit on the far edge so a sprite at the right/bottom limit clips instead of wrapping.
    assign w_x_end = {1'b0, r_px} + SPR_W;
    assign w_y_end = {1'b0, r_py} + SPR_H;
    assign w_hit   = ({1'b0, x} >= {1'b0, r_px}) && ({1'b0, x} < w_x_end) &&
                     ({1'b0, y} >= {1'b0, r_py}) && ({1'b0, y} < w_y_end);

    // Only the low offset bits are needed; they equal the low bits of the full difference.
    assign w_dx = x[SPR_W_LOG2-1:0] - r_px[SPR_W_LOG2-1:0];
    assign w_dy = y[SPR_H_LOG2-1:0] - r_py[SPR_H_LOG2-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_hit_d1 <= 1'b0;
            r_hit_d2 <= 1'b0;
        end else begin
            r_addr   <= w_hit ? {w_anim_idx, w_dy, w_dx} : '0;
            r_hit_d1 <= w_hit;
            r_hit_d2 <= r_hit_d1;
        end
    end

    assign w_en_next = r_hit_d2 && (bmp.ram_dout != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en  <= 1'b0;
            r_rgb <= '0;
        end else begin
            r_en  <= w_en_next;
            r_rgb <= w_en_next ? palette(bmp.ram_dout) : '0;
        end
    end

    assign bmp.addr_r = r_addr;
    assign rgb        = r_rgb;
    assign en         = r_en;

endmodule

// File: doc/water_sprite_gen.md
Name: water_sprite_gen

Overview:
Downstream consumer of the 2-bit water bitmap RAM: turns the current VGA pixel coordinate into a RAM read address, then converts the returned 2-bit colour index into 12-bit RGB plus a pixel-enable.
- Steps through animation frames stored back-to-back in the RAM.
- Latches the sprite position once per frame so the sprite never tears.
- Sits between the VGA sync/pixel counter and the colour mux that composites sprites over the background.

Parameters:
COORD_W, 11, width of pixel coordinates and sprite position
SPR_W_LOG2, 4, log2 sprite width in pixels (16)
SPR_H_LOG2, 4, log2 sprite height in pixels (16)
ANIM_LOG2, 2, log2 number of animation frames (4)
ADDR_WIDTH, 10, RAM address width; must equal SPR_W_LOG2+SPR_H_LOG2+ANIM_LOG2
ANIM_DIV, 8, video frames per animation step (>=1)

Ports:
clk  in  1  pixel clock; the same clock as the RAM
rst_n  in  1  asynchronous, active-low reset
x  in  COORD_W  current pixel column
y  in  COORD_W  current pixel row
frame_tick  in  1  one-cycle pulse at the start of each video frame
anim_en  in  1  1 = animation advances; 0 = animation frozen
pos_x  in  COORD_W  requested sprite left edge
pos_y  in  COORD_W  requested sprite top edge
addr_r  out  ADDR_WIDTH  registered read address to the bitmap RAM
ram_dout  in  2  colour index from the RAM, valid 1 cycle after addr_r
rgb  out  12  sprite colour {R4,G4,B4}
en  out  1  1 = sprite pixel opaque at this position

Behaviour:
Reset, asynchronous on rst_n low:
- addr_r=0, rgb=0, en=0.
- Latched position = (0,0), anim_idx=0, div_cnt=0, pipeline hit flags cleared.
- Reset mid-frame takes effect immediately; outputs are 0 from the next edge after release until a real hit propagates.

Position latch:
- On frame_tick, px<=pos_x and py<=pos_y.
- Hit testing uses only px/py; pos_x/pos_y changes mid-frame have no effect until the next frame_tick.

Animation counter:
- On frame_tick with anim_en=1: if div_cnt==ANIM_DIV-1, then div_cnt<=0 and anim_idx<=anim_idx+1 (wraps from 2^ANIM_LOG2-1 to 0); otherwise div_cnt<=div_cnt+1.
- anim_en=0 holds both counters.
- anim_idx updates in the same cycle as the position latch; the new frame's pixels see both new values.

Stage 1 (cycle N, from x,y):
- hit = (x>=px) && (x<px+2^SPR_W_LOG2) && (y>=py) && (y<py+2^SPR_H_LOG2).
- Sums are computed at COORD_W+1 bits, so a sprite near the coordinate maximum clips and does not wrap.
- addr_r <= hit ? {anim_idx, y-py low SPR_H_LOG2 bits, x-px low SPR_W_LOG2 bits} : 0.
- hit_d1 <= hit.

Stage 2 (cycle N+1):
- The RAM presents ram_dout for addr_r at edge N+2.
- hit_d2 <= hit_d1.

Stage 3 (edge N+2):
- en <= hit_d2 && (ram_dout != 2'b00).
- rgb <= en_next ? palette(ram_dout) : 0.

Latency and timing:
- Total latency from x,y to rgb/en is 3 clocks.
- The consumer delays hsync/vsync/video_on by 3 clocks.
- There is no stall or backpressure; one pixel is accepted every clock.

Palette:
- 00 = transparent, rgb 000.
- 01 = 0x4AF light water.
- 10 = 0x07F mid water.
- 11 = 0xFFF foam.

Boundary rules:
- x == px+W-1 is a hit; x == px+W is not.
- A frame_tick coincident with a hit pixel: that pixel uses the old px/py.
- ANIM_DIV=1 advances anim_idx on every frame_tick.

Decomposition:
- Package water_pkg holds:
  - COORD_W, the sprite size and animation constants;
  - the palette colour constants PAL_LIGHT, PAL_MID, PAL_FOAM;
  - typedef coord_t (logic [COORD_W-1:0]);
  - typedef rgb_t (logic [11:0]).
- One sub-module, water_anim_ctr, contains div_cnt and anim_idx with inputs frame_tick and anim_en, and output anim_idx.
- The hit/address/palette pipeline stays in the top.

Test Plan:
1. Reset: hold rst_n=0 with x,y sweeping -> addr_r=0, rgb=0, en=0 every cycle. Release -> no en until a hit is presented.
2. Basic hit: pos=(100,50) latched by frame_tick, anim_idx=0, RAM model returns 2'b10 at addr 0x011. Drive x=101,y=51 at cycle N -> addr_r=0x011 at N+1; rgb=0x07F and en=1 at N+3.
3. Edges and transparency:
   - x=115,y=65 -> hit, addr 0xFF.
   - x=116 or y=66 or x=99 -> addr_r=0, en=0.
   - A hit where the RAM returns 00 -> en=0, rgb=0.
4. Mid-frame move: change pos_x to 200 without frame_tick -> hits still at x=100..115. After frame_tick -> hits at x=200..215.
5. Animation: ANIM_DIV=8, anim_en=1, 32 frame_ticks -> anim_idx steps 0,1,2,3 every 8 ticks and wraps to 0. Address top bits track it (0x100 offset per step). With anim_en=0 the counters hold.
6. Clipping: pos_x=2040 (COORD_W=11) -> x=2040..2047 hit, x=0..7 not hit. No wrap-around artefact.
